// File: rtl/register_file_if.sv
// Bundles the writeback write port, decode read ports and load scoreboard signals.
interface register_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              Regwrite;
  logic [ADDR_W-1:0] write_reg_address;
  logic [DATA_W-1:0] write_reg_data;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic              mark_busy;
  logic [ADDR_W-1:0] mark_addr;
  logic              rs1_busy;
  logic              rs2_busy;

  // Pipeline side: drives writes, read indices and busy marks; consumes data and busy.
  modport master (
    output Regwrite, write_reg_address, write_reg_data,
    output rs1_addr, rs2_addr, mark_busy, mark_addr,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy
  );

  // Register file side.
  modport slave (
    input  Regwrite, write_reg_address, write_reg_data,
    input  rs1_addr, rs2_addr, mark_busy, mark_addr,
    output rs1_data, rs2_data, rs1_busy, rs2_busy
  );
endinterface

// File: rtl/register_file.sv
// Architectural integer register file: 32 x 32-bit, x0 hardwired to zero,
// two combinational read ports with same-cycle writeback bypass, and a
// per-register load-busy scoreboard used by decode to stall.
module register_file #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int ADDR_W = 5
) (
  input logic            clk,
  input logic            rst,
  register_file_if.slave rf
);

  logic              wr_en_s;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;
  logic [DATA_W-1:0] rs1_data_s;
  logic [DATA_W-1:0] rs2_data_s;
  logic              rs1_busy_s;
  logic              rs2_busy_s;

  // Write enable is active-low and never targets x0.
  always_comb begin
    wr_en_s = (rf.Regwrite == 1'b0) && (rf.write_reg_address != {ADDR_W{1'b0}});
  end

  // Next state: store the write, clear busy on write, then set busy on a new
  // load so that a same-index set overrides the clear (newer load owns it).
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_en_s) begin
      regs_d[rf.write_reg_address] = rf.write_reg_data;
      busy_d[rf.write_reg_address] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (rf.mark_busy && (rf.mark_addr != {ADDR_W{1'b0}})) begin
      busy_d[rf.mark_addr] = 1'b1;
    end else begin
      busy_d[0] = 1'b0;
    end
    regs_d[0] = {DATA_W{1'b0}};
    busy_d[0] = 1'b0;
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
      busy_q <= {NREG{1'b0}};
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Read port 1: zero for x0 or during reset, bypass on a matching write.
  always_comb begin
    if (!rst) begin
      rs1_data_s = {DATA_W{1'b0}};
      rs1_busy_s = 1'b0;
    end else if (rf.rs1_addr == {ADDR_W{1'b0}}) begin
      rs1_data_s = {DATA_W{1'b0}};
      rs1_busy_s = 1'b0;
    end else if (wr_en_s && (rf.write_reg_address == rf.rs1_addr)) begin
      rs1_data_s = rf.write_reg_data;
      rs1_busy_s = 1'b0;
    end else begin
      rs1_data_s = regs_q[rf.rs1_addr];
      rs1_busy_s = busy_q[rf.rs1_addr];
    end
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    if (!rst) begin
      rs2_data_s = {DATA_W{1'b0}};
      rs2_busy_s = 1'b0;
    end else if (rf.rs2_addr == {ADDR_W{1'b0}}) begin
      rs2_data_s = {DATA_W{1'b0}};
      rs2_busy_s = 1'b0;
    end else if (wr_en_s && (rf.write_reg_address == rf.rs2_addr)) begin
      rs2_data_s = rf.write_reg_data;
      rs2_busy_s = 1'b0;
    end else begin
      rs2_data_s = regs_q[rf.rs2_addr];
      rs2_busy_s = busy_q[rf.rs2_addr];
    end
  end

  assign rf.rs1_data = rs1_data_s;
  assign rf.rs2_data = rs2_data_s;
  assign rf.rs1_busy = rs1_busy_s;
  assign rf.rs2_busy = rs2_busy_s;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus a randomized
// run compared against an array-based reference model.
module tb_register_file;

  logic clk;
  logic rst;
  int unsigned checks;
  int unsigned errors;

  logic [31:0] model_regs [32];
  bit          model_busy [32];

  register_file_if #(.DATA_W(32), .ADDR_W(5)) rf ();

  register_file #(.DATA_W(32), .NREG(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected read data from the architectural rules.
  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (!rst || a == 5'd0) return 32'd0;
    if (rf.Regwrite == 1'b0 && rf.write_reg_address == a) return rf.write_reg_data;
    return model_regs[a];
  endfunction

  // Expected busy flag from the architectural rules.
  function automatic bit exp_busy(input logic [4:0] a);
    if (!rst || a == 5'd0) return 1'b0;
    if (rf.Regwrite == 1'b0 && rf.write_reg_address == a) return 1'b0;
    return model_busy[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      model_regs[i] = 32'd0;
      model_busy[i] = 1'b0;
    end
  endtask

  task automatic drive(input logic rw, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic mb, input logic [4:0] ma);
    rf.Regwrite          = rw;
    rf.write_reg_address = wa;
    rf.write_reg_data    = wd;
    rf.rs1_addr          = r1;
    rf.rs2_addr          = r2;
    rf.mark_busy         = mb;
    rf.mark_addr         = ma;
  endtask

  // Advance one clock, updating the model with the inputs seen at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      if (rf.Regwrite == 1'b0 && rf.write_reg_address != 5'd0) begin
        model_regs[rf.write_reg_address] = rf.write_reg_data;
        model_busy[rf.write_reg_address] = 1'b0;
      end
      if (rf.mark_busy && rf.mark_addr != 5'd0) model_busy[rf.mark_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 5'd5, 32'h1234, 5'd5, 5'd0, 1'b1, 5'd5);
    tick();
    drive(1'b1, 5'd0, 32'd0, 5'd5, 5'd5, 1'b0, 5'd0);
    @(negedge clk);
    checks++;
    if (rf.rs1_data !== 32'h1234 || rf.rs1_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_prewrite got %h/%b exp 00001234/1", rf.rs1_data, rf.rs1_busy);
    end
    tick();
    drive(1'b0, 5'd5, 32'h9999, 5'd5, 5'd5, 1'b1, 5'd5);
    #2 rst = 1'b0;
    model_clear();
    #1;
    checks++;
    if (rf.rs1_data !== 32'd0 || rf.rs1_busy !== 1'b0 || rf.rs2_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_asserted got %h/%b exp 0/0", rf.rs1_data, rf.rs1_busy);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 5'd0, 32'd0, 5'd5, 5'd5, 1'b0, 5'd0);
    #1;
    checks++;
    if (rf.rs1_data !== 32'd0 || rf.rs1_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_released got %h/%b exp 0/0", rf.rs1_data, rf.rs1_busy);
    end
    tick();
    checks++;
    if (rf.rs1_data !== 32'd0 || rf.rs2_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard got %h/%b exp 0/0", rf.rs1_data, rf.rs2_busy);
    end
  endtask

  task automatic test_x0();
    drive(1'b0, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 5'd0);
    @(negedge clk);
    checks++;
    if (rf.rs1_data !== 32'd0 || rf.rs2_busy !== 1'b0) begin
      errors++;
      $display("FAIL x0_same_cycle got %h/%b exp 0/0", rf.rs1_data, rf.rs2_busy);
    end
    tick();
    drive(1'b1, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    checks++;
    if (rf.rs1_data !== 32'd0 || rf.rs1_busy !== 1'b0) begin
      errors++;
      $display("FAIL x0_next_cycle got %h/%b exp 0/0", rf.rs1_data, rf.rs1_busy);
    end
    tick();
  endtask

  task automatic test_bypass();
    drive(1'b0, 5'd7, 32'hDEADBEEF, 5'd7, 5'd7, 1'b0, 5'd0);
    @(negedge clk);
    checks++;
    if (rf.rs1_data !== 32'hDEADBEEF || rf.rs2_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL bypass got %h %h exp deadbeef", rf.rs1_data, rf.rs2_data);
    end
    tick();
    drive(1'b1, 5'd7, 32'h0, 5'd7, 5'd7, 1'b0, 5'd0);
    @(negedge clk);
    checks++;
    if (rf.rs1_data !== 32'hDEADBEEF || rf.rs2_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL stored got %h %h exp deadbeef", rf.rs1_data, rf.rs2_data);
    end
    tick();
  endtask

  task automatic test_write_disabled();
    drive(1'b0, 5'd9, 32'h00000011, 5'd0, 5'd0, 1'b0, 5'd0);
    tick();
    drive(1'b1, 5'd9, 32'hAAAA5555, 5'd9, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    checks++;
    if (rf.rs1_data !== 32'h00000011) begin
      errors++;
      $display("FAIL wr_disabled_now got %h exp 00000011", rf.rs1_data);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rf.rs1_data !== 32'h00000011) begin
      errors++;
      $display("FAIL wr_disabled_next got %h exp 00000011", rf.rs1_data);
    end
    tick();
  endtask

  task automatic test_scoreboard();
    drive(1'b1, 5'd0, 32'd0, 5'd0, 5'd3, 1'b1, 5'd3);
    @(negedge clk);
    checks++;
    if (rf.rs2_busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_same_cycle got %b exp 0", rf.rs2_busy);
    end
    tick();
    drive(1'b1, 5'd0, 32'd0, 5'd0, 5'd3, 1'b0, 5'd0);
    @(negedge clk);
    checks++;
    if (rf.rs2_busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_set got %b exp 1", rf.rs2_busy);
    end
    tick();
    drive(1'b0, 5'd3, 32'h42, 5'd0, 5'd3, 1'b0, 5'd0);
    @(negedge clk);
    checks++;
    if (rf.rs2_busy !== 1'b0 || rf.rs2_data !== 32'h42) begin
      errors++;
      $display("FAIL busy_wb got %b/%h exp 0/00000042", rf.rs2_busy, rf.rs2_data);
    end
    tick();
    drive(1'b1, 5'd0, 32'd0, 5'd0, 5'd3, 1'b0, 5'd0);
    @(negedge clk);
    checks++;
    if (rf.rs2_busy !== 1'b0 || rf.rs2_data !== 32'h42) begin
      errors++;
      $display("FAIL busy_after got %b/%h exp 0/00000042", rf.rs2_busy, rf.rs2_data);
    end
    tick();
  endtask

  task automatic test_set_clear();
    drive(1'b0, 5'd4, 32'h44, 5'd0, 5'd0, 1'b1, 5'd4);
    tick();
    drive(1'b1, 5'd0, 32'd0, 5'd4, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    checks++;
    if (rf.rs1_busy !== 1'b1 || rf.rs1_data !== 32'h44) begin
      errors++;
      $display("FAIL set_wins got %b/%h exp 1/00000044", rf.rs1_busy, rf.rs1_data);
    end
    tick();
    drive(1'b0, 5'd4, 32'h45, 5'd0, 5'd0, 1'b1, 5'd6);
    tick();
    drive(1'b1, 5'd0, 32'd0, 5'd4, 5'd6, 1'b0, 5'd0);
    @(negedge clk);
    checks++;
    if (rf.rs1_busy !== 1'b0 || rf.rs2_busy !== 1'b1) begin
      errors++;
      $display("FAIL set_clear_split got %b %b exp 0 1", rf.rs1_busy, rf.rs2_busy);
    end
    tick();
  endtask

  task automatic test_dual_port();
    drive(1'b0, 5'd1, 32'h1, 5'd0, 5'd0, 1'b0, 5'd0);
    tick();
    drive(1'b0, 5'd2, 32'h2, 5'd0, 5'd0, 1'b0, 5'd0);
    tick();
    drive(1'b1, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd2);
    tick();
    drive(1'b1, 5'd0, 32'd0, 5'd1, 5'd2, 1'b0, 5'd0);
    @(negedge clk);
    checks++;
    if (rf.rs1_data !== 32'h1 || rf.rs1_busy !== 1'b0) begin
      errors++;
      $display("FAIL dual_rs1 got %h/%b exp 00000001/0", rf.rs1_data, rf.rs1_busy);
    end
    checks++;
    if (rf.rs2_data !== 32'h2 || rf.rs2_busy !== 1'b1) begin
      errors++;
      $display("FAIL dual_rs2 got %h/%b exp 00000002/1", rf.rs2_data, rf.rs2_busy);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] e1;
    logic [31:0] e2;
    bit          b1;
    bit          b2;
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
            5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
            5'($urandom_range(0, 7)));
      @(negedge clk);
      e1 = exp_data(rf.rs1_addr);
      e2 = exp_data(rf.rs2_addr);
      b1 = exp_busy(rf.rs1_addr);
      b2 = exp_busy(rf.rs2_addr);
      checks++;
      if (rf.rs1_data !== e1 || rf.rs1_busy !== b1) begin
        errors++;
        $display("FAIL rand_rs1 n=%0d addr=%0d got %h/%b exp %h/%b",
                 n, rf.rs1_addr, rf.rs1_data, rf.rs1_busy, e1, b1);
      end
      checks++;
      if (rf.rs2_data !== e2 || rf.rs2_busy !== b2) begin
        errors++;
        $display("FAIL rand_rs2 n=%0d addr=%0d got %h/%b exp %h/%b",
                 n, rf.rs2_addr, rf.rs2_data, rf.rs2_busy, e2, b2);
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    model_clear();
    rst = 1'b0;
    drive(1'b1, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0);
    #2;
    checks++;
    if (rf.rs1_data !== 32'd0 || rf.rs2_data !== 32'd0 || rf.rs1_busy !== 1'b0 || rf.rs2_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got %h %h %b %b exp 0", rf.rs1_data, rf.rs2_data, rf.rs1_busy, rf.rs2_busy);
    end
    #10 rst = 1'b1;
    tick();
    test_reset();
    test_x0();
    test_bypass();
    test_write_disabled();
    test_scoreboard();
    test_set_clear();
    test_dual_port();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Architectural integer register file for the 5-stage pipeline: the receiving end of the writeback-stage write interface and the read source for the decode stage.
- Holds 32 x 32-bit registers. Provides two combinational read ports with write-through bypass from the same-cycle writeback write. x0 is hardwired to zero.
- Carries a per-register load-busy scoreboard. Decode sets an entry when it issues a load; the writeback write clears it. Decode uses rs1_busy/rs2_busy to stall.

Parameters:
- DATA_W, 32, register and data width
- NREG, 32, number of architectural registers (x0..x31)
- ADDR_W, 5, register index width (log2 NREG)

Ports:
- clk  in  1  core clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- Regwrite  in  1  write enable from writeback, ACTIVE-LOW (0 = write)
- write_reg_address  in  ADDR_W  destination index from writeback
- write_reg_data  in  DATA_W  write data from writeback
- rs1_addr  in  ADDR_W  read port 1 index (decode)
- rs2_addr  in  ADDR_W  read port 2 index (decode)
- rs1_data  out  DATA_W  read port 1 data
- rs2_data  out  DATA_W  read port 2 data
- mark_busy  in  1  active-high; decode issued a load whose destination is mark_addr
- mark_addr  in  ADDR_W  load destination index
- rs1_busy  out  1  rs1_addr awaits an outstanding load
- rs2_busy  out  1  rs2_addr awaits an outstanding load

Behaviour:
Reset
- rst low clears all registers to 0 and all busy bits to 0, asynchronously, regardless of clk.
- While rst is low: rs1_data = rs2_data = 0 and rs1_busy = rs2_busy = 0.
- Reset assertion mid-operation discards pending writes and busy marks.

Write
- A write is active when Regwrite == 0 && write_reg_address != 0.
- An active write stores write_reg_data at the posedge.
- Writes to index 0 are discarded.
- Regwrite == 1 means no write; write_reg_address and write_reg_data are don't-care.
- write_reg_data is stored as presented; no X filtering.

Read
- Both ports are combinational; zero-cycle latency.
- If addr == 0: data = 0.
- Else if a write is active and write_reg_address == addr: data = write_reg_data (bypass).
- Else: data = regs[addr].
- Both ports may read the same index; both ports may hit the bypass simultaneously.

Scoreboard
- busy[0] is permanently 0.
- At posedge, if mark_busy && mark_addr != 0: set busy[mark_addr].
- At posedge, if a write is active: clear busy[write_reg_address].
- Simultaneous set and clear on the same index: set wins, because the newer load owns the register.
- Set and clear on different indices both take effect.
- rsN_busy = busy[rsN_addr] && !(write active && write_reg_address == rsN_addr).
  - A register being written this cycle is not busy, because its data is bypassed.
- A mark_busy in the current cycle does not affect the current cycle's rsN_busy.
- mark_busy on an already-busy index leaves it busy; there is no counting.

Timing
- Write-to-read latency is 0 via the bypass; the stored value is visible from the next cycle.
- Busy set is visible to reads the cycle after mark_busy.

Test Plan:
1. Reset/x0:
   - Stimulus: drive rst=0 mid-run after writing x5=0x1234, then release.
   - Required: rs1_addr=5 gives 0 and rs1_busy=0. Separately, a write of 0xFFFFFFFF to x0 with Regwrite=0 leaves rs1_addr=0 reading 0.
2. Active-low write plus bypass:
   - Stimulus: Regwrite=0, addr=7, data=0xDEADBEEF, rs1_addr=rs2_addr=7.
   - Required: both ports read 0xDEADBEEF in the same cycle. Next cycle, with Regwrite=1, both still read 0xDEADBEEF.
3. Write disabled:
   - Stimulus: Regwrite=1, addr=9, data=0xAAAA5555.
   - Required: x9 keeps its prior value 0x00000011, and rs1_data stays 0x00000011 both in that cycle and the next.
4. Scoreboard lifecycle:
   - Stimulus: mark_busy with mark_addr=3, then read rs2_addr=3.
   - Required: rs2_busy=1 from the next cycle. When Regwrite=0, addr=3, data=0x42, rs2_busy=0 and rs2_data=0x42 in that cycle; busy stays clear after.
5. Simultaneous set/clear:
   - Stimulus: same cycle, write to x4 plus mark_busy on x4; separately, write to x4 plus mark_busy on x6.
   - Required: first case leaves busy[4]=1 next cycle. Second case gives busy[4]=0 and busy[6]=1.
6. Dual-port independence:
   - Stimulus: x1=0x1, x2=0x2 stored; x2 marked busy; rs1_addr=1, rs2_addr=2.
   - Required: rs1_data=0x1 with rs1_busy=0; rs2_data=0x2 with rs2_busy=1.
